// File: rtl/efb_spi_wb_sequencer_if.sv
// Wishbone master port toward the EFB SPI register file, plus the fabric-side TX and RX byte streams.
// master = the sequencer's view; slave = the EFB/fabric side.
interface efb_spi_wb_sequencer_if;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       init_done;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready,
    output init_done
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready,
    input  init_done
  );
endinterface

// File: rtl/efb_spi_wb_sequencer.sv
// EFB SPI sequencer: writes CR2/CR1, polls SR, moves RXDR bytes to the rx stream and tx stream bytes to TXDR.
// Latency: each Wishbone access is ack latency + 1; a received byte shows on rx_valid the edge after the RXDR ack.
// Backpressure: rx_ready low fills the RX buffer and RXDR reads stop; EFB_SPI_RX_FIFO_EN selects a 4-deep buffer.
module efb_spi_wb_sequencer #(
  parameter logic [7:0] ADR_CR1  = 8'h55,
  parameter logic [7:0] ADR_CR2  = 8'h56,
  parameter logic [7:0] ADR_TXDR = 8'h59,
  parameter logic [7:0] ADR_SR   = 8'h5A,
  parameter logic [7:0] ADR_RXDR = 8'h5B,
  parameter logic [7:0] CR2_VAL  = 8'h00,
  parameter logic [7:0] CR1_VAL  = 8'h80,
  parameter int         TRDY_BIT = 4,
  parameter int         RRDY_BIT = 3
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  efb_spi_wb_sequencer_if.master bus
);

  typedef enum logic [2:0] {INIT_CR2, INIT_CR1, RD_SR, DECIDE, RD_RX, WR_TX} state_t;

  state_t     state_q, state_d;
  logic       cyc_q, cyc_d, we_q, we_d;
  logic [7:0] adr_q, adr_d, dat_q, dat_d, sr_q, sr_d;
  logic       init_done_q, init_done_d;
  logic       ack, tx_take, rx_push, rx_pop, rx_full, rx_vld;
  logic [7:0] rx_head;

  // Acks outside an active cycle are ignored.
  assign ack = cyc_q && bus.wb_ack_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= INIT_CR2;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sr_q        <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sr_q        <= sr_d;
      init_done_q <= init_done_d;
    end
  end

  // A bus state with cyc low has not issued yet; once issued it holds until ack.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sr_d        = sr_q;
    init_done_d = init_done_q;
    tx_take     = 1'b0;
    rx_push     = 1'b0;
    case (state_q)
      INIT_CR2: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_CR2; dat_d = CR2_VAL;
        end else if (ack) begin
          cyc_d = 1'b0; state_d = INIT_CR1;
        end
      end
      INIT_CR1: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_CR1; dat_d = CR1_VAL;
        end else if (ack) begin
          cyc_d = 1'b0; init_done_d = 1'b1; state_d = RD_SR;
        end
      end
      RD_SR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_SR;
        end else if (ack) begin
          cyc_d = 1'b0; sr_d = bus.wb_dat_i; state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (sr_q[RRDY_BIT] && !rx_full) begin
          state_d = RD_RX;
        end else if (sr_q[TRDY_BIT] && bus.tx_valid) begin
          tx_take = 1'b1; dat_d = bus.tx_data; state_d = WR_TX;
        end else begin
          state_d = RD_SR;
        end
      end
      RD_RX: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_RXDR;
        end else if (ack) begin
          cyc_d = 1'b0; rx_push = 1'b1; sr_d[RRDY_BIT] = 1'b0; state_d = DECIDE;
        end
      end
      WR_TX: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_TXDR;
        end else if (ack) begin
          cyc_d = 1'b0; sr_d[TRDY_BIT] = 1'b0; state_d = RD_SR;
        end
      end
      default: state_d = INIT_CR2;
    endcase
  end

  assign rx_pop = rx_vld && bus.rx_ready;

`ifdef EFB_SPI_RX_FIFO_EN
  logic [7:0] rx_mem [4];
  logic [1:0] rx_wr_ptr, rx_rd_ptr;
  logic [2:0] rx_cnt;

  assign rx_full = (rx_cnt == 3'd4);
  assign rx_vld  = (rx_cnt != 3'd0);
  assign rx_head = rx_mem[rx_rd_ptr];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 4; i++) rx_mem[i] <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr_ptr] <= bus.wb_dat_i;
        rx_wr_ptr         <= rx_wr_ptr + 2'd1;
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 2'd1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 3'd1;
        2'b01:   rx_cnt <= rx_cnt - 3'd1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_hold_vld;

  assign rx_full = rx_hold_vld;
  assign rx_vld  = rx_hold_vld;
  assign rx_head = rx_hold;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_hold     <= '0;
      rx_hold_vld <= 1'b0;
    end else if (rx_push) begin
      rx_hold     <= bus.wb_dat_i;
      rx_hold_vld <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_vld <= 1'b0;
    end
  end
`endif

  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.tx_ready  = tx_take;
  assign bus.rx_data   = rx_head;
  assign bus.rx_valid  = rx_vld;
  assign bus.init_done = init_done_q;

endmodule

// File: doc/efb_spi_wb_sequencer.md
# efb_spi_wb_sequencer

Wishbone master that drives the EFB hard SPI slave's register port and converts it into two byte streams for fabric logic. After reset it writes the SPI control registers to enable the core. It then polls the SPI status register. It reads each received byte into an RX buffer and writes queued TX bytes into the transmit data register. It sits directly upstream of the EFB Wishbone slave port and downstream of whatever fabric logic produces or consumes SPI payload bytes.

## Interface
Parameters:
- ADR_CR1, 8'h55: SPI control register 1 address (enable).
- ADR_CR2, 8'h56: SPI control register 2 address (mode).
- ADR_TXDR, 8'h59: transmit data register address.
- ADR_SR, 8'h5A: status register address.
- ADR_RXDR, 8'h5B: receive data register address.
- CR2_VAL, 8'h00: value written to CR2 during init.
- CR1_VAL, 8'h80: value written to CR1 during init (SPI enable).
- TRDY_BIT, 4: SR bit index, transmit register empty.
- RRDY_BIT, 3: SR bit index, receive register full.

Ports:
- wb_clk_i, in, 1: single clock.
- wb_rst_i, in, 1: asynchronous, active-high reset.
- wb_cyc_o, wb_stb_o, wb_we_o, out, 1 each: Wishbone master controls.
- wb_adr_o, out, 8: register address.
- wb_dat_o, out, 8: write data.
- wb_dat_i, in, 8: read data.
- wb_ack_i, in, 1: cycle acknowledge.
- tx_data, in, 8: byte to transmit.
- tx_valid, in, 1: TX stream valid.
- tx_ready, out, 1: TX stream ready; a byte transfers when tx_valid and tx_ready are both high.
- rx_data, out, 8: received byte (head of RX buffer).
- rx_valid, out, 1: RX buffer not empty.
- rx_ready, in, 1: consumer pops rx_data when rx_valid and rx_ready are both high.
- init_done, out, 1: high once both init writes have been acknowledged.

## Operation
- FSM states: INIT_CR2, INIT_CR1, RD_SR, DECIDE, RD_RX, WR_TX.
- Reset enters INIT_CR2. The init sequence is the CR2_VAL write, then the CR1_VAL write. After the CR1 ack, init_done is set and stays high until reset; the FSM goes to RD_SR.
- RD_SR: read ADR_SR. The read data is latched into sr_q on ack. Next state is DECIDE.
- DECIDE takes one cycle with no bus activity:
  - sr_q[RRDY_BIT] set and RX buffer not full: go to RD_RX.
  - Otherwise, sr_q[TRDY_BIT] set and tx_valid high: assert tx_ready for this cycle, capture tx_data into the write-data register, go to WR_TX.
  - Otherwise: go to RD_SR.
- RD_RX: read ADR_RXDR. On ack, push wb_dat_i into the RX buffer and clear sr_q[RRDY_BIT]. Return to DECIDE, so a pending TX is serviced without re-polling.
- WR_TX: write the captured byte to ADR_TXDR. On ack, clear sr_q[TRDY_BIT] and go to RD_SR.
- RRDY with a full RX buffer: the byte is left in the EFB, no read is issued, and the TX path is still evaluated. Overrun is the EFB's concern; this block never drops bytes itself.
- RX buffer:
  - Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
  - Simultaneous push and pop on an empty buffer is impossible, because pop requires rx_valid.
- tx_ready is high only in the single DECIDE cycle that selects WR_TX; at all other times it is 0.

## Timing
- Reset values:
  - Outputs: wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, tx_ready=0, rx_valid=0, rx_data=0, init_done=0.
  - Internal: sr_q=0, RX buffer empty.
- Bus cycle rules:
  - cyc and stb assert together, registered, in the first cycle of a bus state.
  - adr, we and dat are stable while stb is high.
  - On the cycle wb_ack_i is sampled high, cyc/stb deassert on the next edge and the FSM advances. Each bus access therefore costs ack latency + 1 cycle.
  - There is no timeout; an ack that never arrives stalls the block.
- A wb_ack_i arriving while cyc is low is ignored.
- Reset asserted mid-cycle drops cyc/stb immediately (asynchronous) and restarts init. The RX buffer contents are discarded.
- rx_valid rises on the edge after the RD_RX ack.
- Minimum RX turnaround is SR read + DECIDE + RXDR read.

## Configuration
- EFB_SPI_RX_FIFO_EN defined: the RX buffer is a 4-entry FIFO with 2-bit wrapping read and write pointers and a 3-bit count; full when count=4.
- EFB_SPI_RX_FIFO_EN undefined: the RX buffer is a single holding register; full whenever rx_valid=1.

## Test plan
- Init: release reset with a slave model acking after 2 cycles -> write 0x56←0x00 then 0x55←0x80; init_done high after the second ack; first read targets 0x5A.
- RX path: SR returns 0x08, RXDR returns 0xA5, rx_ready=1 -> rx_data=0xA5 with rx_valid high for one cycle; the SR poll resumes.
- TX path: tx_valid=1, tx_data=0x3C, SR returns 0x10 -> tx_ready pulses once; write 0x59←0x3C; tx_ready stays low until TRDY is seen again.
- Combined: SR=0x18 with tx_valid=1 -> read 0x5B, then write 0x59, with no SR read between them.
- Backpressure: rx_ready=0, SR always 0x08:
  - With EFB_SPI_RX_FIFO_EN: exactly 4 RXDR reads, then none.
  - Without it: exactly 1 read.
  - In both cases, raising rx_ready resumes reads and returns bytes in arrival order.
- Reset mid-cycle: assert wb_rst_i while stb is high during WR_TX -> cyc/stb are 0 within the same cycle, and the bus restarts with the 0x56 init write.
